// File: rtl/tlb_each_line_if.sv
// Lookup, operation and hit signals shared between the TLB control logic and one TLB line.
// The master side drives the keys and operation, and the line answers with its hit flags.
interface tlb_each_line_if #(
  parameter int VPN_WIDTH = 19
);
  logic [VPN_WIDTH-1:0] in_VPN_instruction;
  logic [VPN_WIDTH-1:0] in_VPN_data;
  logic [2:0]           op_type;
  logic                 sel_index;
  logic                 sel_random;
  logic [31:0]          in_EntryHi;
  logic [31:0]          in_EntryLo0;
  logic [31:0]          in_EntryLo1;
  logic                 unmapped_instruction;
  logic                 unmapped_data;
  logic                 load_store;
  logic                 hit_instruction;
  logic                 hit_data;
  logic                 tlbp_hit;

  modport master (
    output in_VPN_instruction, in_VPN_data, op_type, sel_index, sel_random,
           in_EntryHi, in_EntryLo0, in_EntryLo1,
           unmapped_instruction, unmapped_data, load_store,
    input  hit_instruction, hit_data, tlbp_hit
  );

  modport slave (
    input  in_VPN_instruction, in_VPN_data, op_type, sel_index, sel_random,
           in_EntryHi, in_EntryLo0, in_EntryLo1,
           unmapped_instruction, unmapped_data, load_store,
    output hit_instruction, hit_data, tlbp_hit
  );
endinterface

// File: rtl/tlb_each_line.sv
// One fully associative TLB line holding an even/odd page-pair mapping.
// It matches the instruction, data and probe keys, and it drives the shared tri-state result buses.
module tlb_each_line #(
  parameter int VPN_WIDTH = 19,
  parameter int PFN_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  tlb_each_line_if.slave         bus,
  output wire [1:0]              out_PFN_data_D,
  output wire [2*PFN_WIDTH-1:0]  out_PFN_instruction,
  output wire [1:0]              out_PFN_instruction_valid,
  output wire [2*PFN_WIDTH-1:0]  out_PFN_data,
  output wire [1:0]              out_PFN_data_valid,
  output wire [31:0]             out_EntryHi,
  output wire [31:0]             out_EntryLo0,
  output wire [31:0]             out_EntryLo1
);

  localparam logic [2:0] OP_TLBR  = 3'b001;
  localparam logic [2:0] OP_TLBWI = 3'b010;
  localparam logic [2:0] OP_TLBWR = 3'b011;
  localparam logic [2:0] OP_TLBP  = 3'b100;

  logic [VPN_WIDTH-1:0] vpn2_q, vpn2_d;
  logic [7:0]           asid_q, asid_d;
  logic                 g_q, g_d;
  logic [PFN_WIDTH-1:0] pfn0_q, pfn0_d, pfn1_q, pfn1_d;
  logic [2:0]           c0_q, c0_d, c1_q, c1_d;
  logic                 d0_q, d0_d, d1_q, d1_d;
  logic                 v0_q, v0_d, v1_q, v1_d;
  logic                 used_q, used_d;

  logic write_en;
  assign write_en = ((bus.op_type == OP_TLBWI) && bus.sel_index) ||
                    ((bus.op_type == OP_TLBWR) && bus.sel_random);

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path leaves it unassigned and no latch is inferred.
    vpn2_d = vpn2_q;
    asid_d = asid_q;
    g_d    = g_q;
    pfn0_d = pfn0_q;
    pfn1_d = pfn1_q;
    c0_d   = c0_q;
    c1_d   = c1_q;
    d0_d   = d0_q;
    d1_d   = d1_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    used_d = used_q;
    if (write_en) begin
      vpn2_d = bus.in_EntryHi[31 -: VPN_WIDTH];
      asid_d = bus.in_EntryHi[7:0];
      g_d    = bus.in_EntryLo0[0] & bus.in_EntryLo1[0];
      pfn0_d = bus.in_EntryLo0[6 +: PFN_WIDTH];
      pfn1_d = bus.in_EntryLo1[6 +: PFN_WIDTH];
      c0_d   = bus.in_EntryLo0[5:3];
      c1_d   = bus.in_EntryLo1[5:3];
      d0_d   = bus.in_EntryLo0[2];
      d1_d   = bus.in_EntryLo1[2];
      v0_d   = bus.in_EntryLo0[1];
      v1_d   = bus.in_EntryLo1[1];
      used_d = 1'b1;
    end
  end

  // NOTE: every stored field is reset, not just `used`, because TLBR must read a never-written line back as zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpn2_q <= '0;
      asid_q <= '0;
      g_q    <= 1'b0;
      pfn0_q <= '0;
      pfn1_q <= '0;
      c0_q   <= '0;
      c1_q   <= '0;
      d0_q   <= 1'b0;
      d1_q   <= 1'b0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      used_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates mean a lookup in the same cycle still sees the old contents.
      vpn2_q <= vpn2_d;
      asid_q <= asid_d;
      g_q    <= g_d;
      pfn0_q <= pfn0_d;
      pfn1_q <= pfn1_d;
      c0_q   <= c0_d;
      c1_q   <= c1_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      used_q <= used_d;
    end
  end

  logic asid_ok, match_instr, match_data, match_probe, read_en;
  assign asid_ok     = g_q || (asid_q == bus.in_EntryHi[7:0]);
  assign match_instr = used_q && asid_ok && (vpn2_q == bus.in_VPN_instruction);
  assign match_data  = used_q && asid_ok && (vpn2_q == bus.in_VPN_data);
  assign match_probe = used_q && asid_ok && (vpn2_q == bus.in_EntryHi[31 -: VPN_WIDTH]);

  assign bus.hit_instruction = match_instr && !bus.unmapped_instruction;
  assign bus.hit_data        = match_data && bus.load_store && !bus.unmapped_data;
  assign bus.tlbp_hit        = (bus.op_type == OP_TLBP) && match_probe;
  // Reset gates the readback explicitly so the bus floats for as long as rst is held.
  assign read_en             = !rst && (bus.op_type == OP_TLBR) && bus.sel_index;

  assign out_PFN_instruction       = bus.hit_instruction ? {pfn1_q, pfn0_q} : 'z;
  assign out_PFN_instruction_valid = bus.hit_instruction ? {v1_q, v0_q}     : 'z;
  assign out_PFN_data              = bus.hit_data ? {pfn1_q, pfn0_q} : 'z;
  assign out_PFN_data_valid        = bus.hit_data ? {v1_q, v0_q}     : 'z;
  assign out_PFN_data_D            = bus.hit_data ? {d1_q, d0_q}     : 'z;

  assign out_EntryHi  = read_en ? {vpn2_q, {(32-VPN_WIDTH-8){1'b0}}, asid_q} : 'z;
  assign out_EntryLo0 = read_en ? {{(32-PFN_WIDTH-6){1'b0}}, pfn0_q, c0_q, d0_q, v0_q, g_q} : 'z;
  assign out_EntryLo1 = read_en ? {{(32-PFN_WIDTH-6){1'b0}}, pfn1_q, c1_q, d1_q, v1_q, g_q} : 'z;

endmodule

// File: tb/tb_tlb_each_line.sv
// Directed bench for one TLB line. The result buses are pulled up here,
// so a bus that no line drives reads as all ones.
module tb_tlb_each_line;

  logic clk;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;

  tlb_each_line_if #(.VPN_WIDTH(19)) bus_if ();

  tri1 [1:0]  pfn_data_d;
  tri1 [47:0] pfn_instr;
  tri1 [1:0]  pfn_instr_valid;
  tri1 [47:0] pfn_data;
  tri1 [1:0]  pfn_data_valid;
  tri1 [31:0] entry_hi;
  tri1 [31:0] entry_lo0;
  tri1 [31:0] entry_lo1;

  tlb_each_line #(.VPN_WIDTH(19), .PFN_WIDTH(24)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .bus                       (bus_if.slave),
    .out_PFN_data_D            (pfn_data_d),
    .out_PFN_instruction       (pfn_instr),
    .out_PFN_instruction_valid (pfn_instr_valid),
    .out_PFN_data              (pfn_data),
    .out_PFN_data_valid        (pfn_data_valid),
    .out_EntryHi               (entry_hi),
    .out_EntryLo0              (entry_lo0),
    .out_EntryLo1              (entry_lo1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  localparam logic [47:0] PFN_PAIR = {24'h000456, 24'h000123};
  localparam logic [47:0] FLOAT48  = '1;

  initial begin
    rst = 1'b1;
    bus_if.in_VPN_instruction   = '0;
    bus_if.in_VPN_data          = '0;
    bus_if.op_type              = 3'b000;
    bus_if.sel_index            = 1'b0;
    bus_if.sel_random           = 1'b0;
    bus_if.in_EntryHi           = '0;
    bus_if.in_EntryLo0          = '0;
    bus_if.in_EntryLo1          = '0;
    bus_if.unmapped_instruction = 1'b0;
    bus_if.unmapped_data        = 1'b0;
    bus_if.load_store           = 1'b1;
    #2;
    check("rst_hit_i", 64'(bus_if.hit_instruction), 64'd0);
    check("rst_hit_d", 64'(bus_if.hit_data), 64'd0);
    check("rst_tlbp", 64'(bus_if.tlbp_hit), 64'd0);
    check("rst_bus_i", 64'(pfn_instr), 64'(FLOAT48));
    check("rst_bus_d", 64'(pfn_data), 64'(FLOAT48));
    check("rst_bus_dd", 64'(pfn_data_d), 64'd3);

    bus_if.op_type = 3'b001; bus_if.sel_index = 1'b1;
    #1 check("rst_tlbr_hi", 64'(entry_hi), 64'hFFFF_FFFF);

    // A write attempted while rst is high must be ignored.
    bus_if.op_type     = 3'b010;
    bus_if.in_EntryHi  = 32'h0040_0005;
    bus_if.in_EntryLo0 = 32'hC000_48DE;
    bus_if.in_EntryLo1 = 32'h0001_1592;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus_if.op_type = 3'b001;
    #1;
    check("unwritten_hi", 64'(entry_hi), 64'd0);
    check("unwritten_lo0", 64'(entry_lo0), 64'd0);
    check("unwritten_lo1", 64'(entry_lo1), 64'd0);

    // TLBWI: same-cycle lookup still sees the empty line.
    @(negedge clk);
    bus_if.op_type            = 3'b010;
    bus_if.in_VPN_instruction = 19'h00200;
    bus_if.in_VPN_data        = 19'h00200;
    #1 check("wr_same_cycle", 64'(bus_if.hit_instruction), 64'd0);
    @(posedge clk);
    #1 check("wr_next_cycle", 64'(bus_if.hit_instruction), 64'd1);

    @(negedge clk);
    bus_if.op_type = 3'b000; bus_if.sel_index = 1'b0;
    #1;
    check("lk_pfn_i", 64'(pfn_instr), 64'(PFN_PAIR));
    check("lk_valid_i", 64'(pfn_instr_valid), 64'd3);
    check("lk_hit_d", 64'(bus_if.hit_data), 64'd1);
    check("lk_pfn_d", 64'(pfn_data), 64'(PFN_PAIR));
    check("lk_dflags", 64'(pfn_data_d), 64'd1);
    check("lk_valid_d", 64'(pfn_data_valid), 64'd3);

    bus_if.op_type = 3'b001; bus_if.sel_index = 1'b1;
    #1;
    check("tlbr_hi", 64'(entry_hi), 64'h0040_0005);
    check("tlbr_lo0", 64'(entry_lo0), 64'h0000_48DE);
    check("tlbr_lo1", 64'(entry_lo1), 64'h0001_1592);
    bus_if.sel_index = 1'b0;
    #1 check("tlbr_unsel", 64'(entry_hi), 64'hFFFF_FFFF);

    bus_if.op_type = 3'b100;
    #1 check("tlbp_hit", 64'(bus_if.tlbp_hit), 64'd1);
    bus_if.op_type = 3'b000;
    #1 check("tlbp_op0", 64'(bus_if.tlbp_hit), 64'd0);
    bus_if.op_type = 3'b100; bus_if.in_EntryHi = 32'h0040_2005;
    #1 check("tlbp_vpn", 64'(bus_if.tlbp_hit), 64'd0);

    bus_if.op_type = 3'b000; bus_if.in_EntryHi = 32'h0040_0006;
    #1;
    check("asid6_hit", 64'(bus_if.hit_instruction), 64'd0);
    check("asid6_bus", 64'(pfn_instr), 64'(FLOAT48));
    bus_if.op_type = 3'b100;
    #1 check("asid6_tlbp", 64'(bus_if.tlbp_hit), 64'd0);

    // Operations that must not write: reserved opcode, unselected WI, unselected WR.
    @(negedge clk);
    bus_if.op_type = 3'b101; bus_if.sel_index = 1'b1; bus_if.sel_random = 1'b1;
    bus_if.in_EntryHi = 32'h0080_0007; bus_if.in_EntryLo0 = '0; bus_if.in_EntryLo1 = '0;
    @(negedge clk);
    bus_if.op_type = 3'b010; bus_if.sel_index = 1'b0; bus_if.sel_random = 1'b1;
    @(negedge clk);
    bus_if.op_type = 3'b011; bus_if.sel_index = 1'b1; bus_if.sel_random = 1'b0;
    @(negedge clk);
    bus_if.op_type = 3'b001; bus_if.sel_index = 1'b1;
    #1;
    check("nowrite_hi", 64'(entry_hi), 64'h0040_0005);
    check("nowrite_lo0", 64'(entry_lo0), 64'h0000_48DE);

    // TLBWR with both selects high, global in both words.
    @(negedge clk);
    bus_if.op_type = 3'b011; bus_if.sel_index = 1'b1; bus_if.sel_random = 1'b1;
    bus_if.in_EntryHi = 32'h0040_0005; bus_if.in_EntryLo0 = 32'h0000_48DF; bus_if.in_EntryLo1 = 32'h0001_1593;
    @(negedge clk);
    bus_if.op_type = 3'b000; bus_if.sel_random = 1'b0; bus_if.in_EntryHi = 32'h0040_0006;
    #1;
    check("global_hit", 64'(bus_if.hit_instruction), 64'd1);
    check("global_pfn", 64'(pfn_instr), 64'(PFN_PAIR));
    bus_if.op_type = 3'b001;
    #1;
    check("global_lo0", 64'(entry_lo0), 64'h0000_48DF);
    check("global_lo1", 64'(entry_lo1), 64'h0001_1593);

    // G set in only one word leaves the line non-global.
    @(negedge clk);
    bus_if.op_type = 3'b010; bus_if.in_EntryHi = 32'h0040_0005;
    bus_if.in_EntryLo0 = 32'h0000_48DF; bus_if.in_EntryLo1 = 32'h0001_1592;
    @(negedge clk);
    bus_if.op_type = 3'b000; bus_if.in_EntryHi = 32'h0040_0006;
    #1 check("half_g_hit", 64'(bus_if.hit_instruction), 64'd0);
    bus_if.op_type = 3'b001;
    #1 check("half_g_lo0", 64'(entry_lo0), 64'h0000_48DE);

    bus_if.op_type = 3'b000; bus_if.in_EntryHi = 32'h0040_0005;
    bus_if.unmapped_instruction = 1'b1;
    #1;
    check("unmap_i_hit", 64'(bus_if.hit_instruction), 64'd0);
    check("unmap_i_bus", 64'(pfn_instr), 64'(FLOAT48));
    check("unmap_i_dhit", 64'(bus_if.hit_data), 64'd1);
    bus_if.unmapped_instruction = 1'b0; bus_if.load_store = 1'b0;
    #1;
    check("ls0_hit_d", 64'(bus_if.hit_data), 64'd0);
    check("ls0_bus_d", 64'(pfn_data), 64'(FLOAT48));
    check("ls0_dflags", 64'(pfn_data_d), 64'd3);
    check("ls0_hit_i", 64'(bus_if.hit_instruction), 64'd1);
    bus_if.load_store = 1'b1; bus_if.unmapped_data = 1'b1;
    #1 check("unmap_d_hit", 64'(bus_if.hit_data), 64'd0);
    bus_if.unmapped_data = 1'b0; bus_if.in_VPN_data = 19'h00201;
    #1 check("vpn_d_miss", 64'(bus_if.hit_data), 64'd0);
    bus_if.in_VPN_data = 19'h00200;

    // Asynchronous reset mid-cycle, away from any clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_hit_i", 64'(bus_if.hit_instruction), 64'd0);
    check("arst_hit_d", 64'(bus_if.hit_data), 64'd0);
    check("arst_bus_i", 64'(pfn_instr), 64'(FLOAT48));
    bus_if.op_type = 3'b001;
    #1 check("arst_tlbr", 64'(entry_hi), 64'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_lo0", 64'(entry_lo0), 64'd0);
    check("arst_hi", 64'(entry_hi), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
